adder_cs_pipe: RTL and testbench
================================

ADDER_CS_PIPE -- requirements
Module: adder_cs_pipe

Interface
REQ-001 WIDTH, 64, operand/sum width in bits; SHALL be a positive multiple of SEG.
REQ-002 SEG, 16, carry-select segment width in bits; NSEG = WIDTH/SEG SHALL be >= 2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-005 inValid  input  1  operand transfer request.
REQ-006 inReady  output  1  block can accept operands this cycle.
REQ-007 inA  input  WIDTH  operand A.
REQ-008 inB  input  WIDTH  operand B.
REQ-009 inCarry  input  1  carry-in, add mode only.
REQ-010 inSub  input  1  1 = subtract (A - B), 0 = add.
REQ-011 outValid  output  1  result present.
REQ-012 outReady  input  1  consumer accepts the result this cycle.
REQ-013 outSum  output  WIDTH  result bits.
REQ-014 outCarry  output  1  carry-out of bit WIDTH-1.

Function
REQ-015 Input transfer SHALL occur when inValid && inReady; output transfer SHALL occur when outValid && outReady.
REQ-016 Pipeline SHALL have NSEG stages; stage k resolves segment k (bits k*SEG+SEG-1 : k*SEG).
REQ-017 Each segment SHALL compute its sum and carry for carry-in 0 and for carry-in 1 in parallel; the carry registered from segment k-1 SHALL select the result.
REQ-018 Operand bits of not-yet-resolved segments and already-resolved sum bits SHALL be carried forward in skew registers alongside each stage.
REQ-019 Add mode: {outCarry,outSum} SHALL equal inA + inB + inCarry, modulo 2^(WIDTH+1).
REQ-020 Subtract mode: B SHALL be inverted and carry-in forced to 1 (inCarry ignored); outCarry = 1 means no borrow (A >= B unsigned).
REQ-021 Latency SHALL be exactly NSEG cycles from input transfer to outValid when the pipeline is not stalled.
REQ-022 Global advance enable SHALL be en = outReady || !outValid; inReady SHALL equal en (combinational from outReady and state).
REQ-023 When en = 0, every stage register, valid bit, and output SHALL hold.
REQ-024 Bubbles SHALL propagate as invalid stages; a new input SHALL be accepted on any cycle en = 1, giving throughput of one result per cycle.
REQ-025 Simultaneous input and output transfer in one cycle SHALL be lossless.
REQ-026 outSum/outCarry SHALL be stable while outValid && !outReady.
REQ-027 Data registers of invalid stages are don't-care; outSum/outCarry SHALL read 0 when outValid = 0.

Reset
REQ-028 While rst_n = 0 at a rising edge, all stage valid bits SHALL clear and all in-flight operations SHALL be discarded.
REQ-029 Reset values: outValid = 0, outSum = 0, outCarry = 0; inReady SHALL be 1 from the first cycle after reset.
REQ-030 An input presented in the same cycle as an asserted reset SHALL NOT be accepted.

Configuration
REQ-031 Macro ADDER_CS_PIPE_OVF_EN defined: extra output outOverflow (1 bit) SHALL be registered with the result and SHALL flag two's-complement signed overflow of the operation performed (add or subtract); reset value 0, reads 0 when outValid = 0.
REQ-032 Macro undefined: port outOverflow and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-033 Package adder_cs_pkg SHALL hold default WIDTH/SEG constants and the stage-register struct typedef (valid, sub, resolved sum, pending A/B, carry).
REQ-034 Sub-module adder_cs_seg (SEG-wide dual-carry segment plus select) SHALL be instantiated once per stage.

Verification
REQ-035 Add, WIDTH=64/SEG=16: A=0xFFFF_FFFF_FFFF_FFFF, B=0, inCarry=1 -> outSum=0, outCarry=1, outValid exactly 4 cycles after accept.
REQ-036 Subtract: A=5, B=7 -> outSum=0xFFFF_FFFF_FFFF_FFFE, outCarry=0; A=7, B=5 -> outSum=2, outCarry=1.
REQ-037 Back-to-back streaming of 100 random operands with outReady=1 -> one result per cycle, in order, matching the reference model.
REQ-038 Hold outReady=0 for 6 cycles with the pipe full -> inReady=0, outSum stable, no loss or duplication after release.
REQ-039 Assert rst_n=0 with 3 operations in flight -> outValid=0 the next cycle and no stale result ever emerges.
REQ-040 With ADDER_CS_PIPE_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> outOverflow=1; A=0x8000_0000_0000_0000, B=1, subtract -> outOverflow=1; A=1, B=1, add -> outOverflow=0.

Source files
------------

// File: rtl/adder_cs_pkg.sv
// Shared constants and stage-register layout for the carry-select adder pipeline.
// Optional overflow output is enabled by ADDER_CS_PIPE_OVF_EN in adder_cs_pipe.
package adder_cs_pkg;

    localparam int unsigned CsWidth = 64;
    localparam int unsigned CsSeg   = 16;

    // One pipeline stage: resolved low sum bits plus the operands still to be resolved.
    typedef struct packed {
        logic               valid;
        logic               sub;
        logic [CsWidth-1:0] sum;
        logic [CsWidth-1:0] a;
        logic [CsWidth-1:0] b;
        logic               carry;
    } cs_stage_t;

endpackage

// File: rtl/adder_cs_seg.sv
// One carry-select segment: sums for carry-in 0 and 1 are formed in parallel,
// then the incoming carry picks one. B is inverted here in subtract mode.
module adder_cs_seg #(
    parameter int unsigned SEG = 16
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           sub_i,
    input  logic           cin_i,
    output logic [SEG-1:0] sum_o,
    output logic           cout_o
);

    logic [SEG-1:0] b_eff;
    logic [SEG:0]   res0;
    logic [SEG:0]   res1;

    always_comb begin
        b_eff = b_i ^ {SEG{sub_i}};
        res0  = {1'b0, a_i} + {1'b0, b_eff};
        res1  = {1'b0, a_i} + {1'b0, b_eff} + {{SEG{1'b0}}, 1'b1};
        {cout_o, sum_o} = cin_i ? res1 : res0;
    end

endmodule

// File: rtl/adder_cs_pipe.sv
// NSEG-stage carry-select adder/subtractor with valid/ready handshake and global stall.
// Define ADDER_CS_PIPE_OVF_EN to add the registered signed-overflow output outOverflow.
module adder_cs_pipe
    import adder_cs_pkg::*;
#(
    parameter int unsigned WIDTH = CsWidth,
    parameter int unsigned SEG   = CsSeg
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inCarry,
    input  logic             inSub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outSum,
`ifdef ADDER_CS_PIPE_OVF_EN
    output logic             outOverflow,
`endif
    output logic             outCarry
);

    localparam int unsigned NSEG = WIDTH / SEG;
    localparam int unsigned Last = NSEG - 1;

    cs_stage_t      src  [NSEG];
    cs_stage_t      st_d [NSEG];
    cs_stage_t      st_q [NSEG];
    logic [SEG-1:0] seg_a    [NSEG];
    logic [SEG-1:0] seg_b    [NSEG];
    logic [SEG-1:0] seg_sum  [NSEG];
    logic           seg_sub  [NSEG];
    logic           seg_cin  [NSEG];
    logic           seg_cout [NSEG];
    logic           en;

    assign en      = outReady || !outValid;
    assign inReady = en;

    // Stage k works on what stage k-1 holds; stage 0 works directly on the inputs.
    always_comb begin
        src[0]       = '0;
        src[0].valid = inValid;
        src[0].sub   = inSub;
        src[0].a     = CsWidth'(inA);
        src[0].b     = CsWidth'(inB);
        src[0].carry = inSub | inCarry;
        for (int k = 1; k < NSEG; k++) begin
            src[k] = st_q[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            seg_a[k]   = src[k].a[k*SEG +: SEG];
            seg_b[k]   = src[k].b[k*SEG +: SEG];
            seg_sub[k] = src[k].sub;
            seg_cin[k] = src[k].carry;
        end
    end

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        adder_cs_seg #(
            .SEG (SEG)
        ) u_seg (
            .a_i    (seg_a[g]),
            .b_i    (seg_b[g]),
            .sub_i  (seg_sub[g]),
            .cin_i  (seg_cin[g]),
            .sum_o  (seg_sum[g]),
            .cout_o (seg_cout[g])
        );
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            st_d[k]                    = src[k];
            st_d[k].sum[k*SEG +: SEG]  = seg_sum[k];
            st_d[k].carry              = seg_cout[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                st_q[k].valid <= 1'b0;
            end
        end else if (en) begin
            st_q <= st_d;
        end
    end

    assign outValid = st_q[Last].valid;
    assign outSum   = outValid ? st_q[Last].sum[WIDTH-1:0] : '0;
    assign outCarry = outValid & st_q[Last].carry;

`ifdef ADDER_CS_PIPE_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow: operand signs agree (B as actually added) but the result sign differs.
    always_comb begin
        ovf_d = (src[Last].a[WIDTH-1] == (src[Last].b[WIDTH-1] ^ src[Last].sub)) &&
                (seg_sum[Last][SEG-1] != src[Last].a[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign outOverflow = outValid & ovf_q;
`endif

endmodule

// File: tb/tb_adder_cs_pipe.sv
// Self-checking bench for adder_cs_pipe: arithmetic reference model plus queue scoreboard.
// Overflow checks are compiled in when ADDER_CS_PIPE_OVF_EN is defined.
module tb_adder_cs_pipe;

    localparam int WIDTH = 64;
    localparam int SEG   = 16;
    localparam int NSEG  = WIDTH / SEG;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              inValid;
    logic              inReady;
    logic [WIDTH-1:0]  inA;
    logic [WIDTH-1:0]  inB;
    logic              inCarry;
    logic              inSub;
    logic              outValid;
    logic              outReady;
    logic [WIDTH-1:0]  outSum;
    logic              outCarry;
`ifdef ADDER_CS_PIPE_OVF_EN
    logic              outOverflow;
`endif

    always #5 clk = ~clk;

    adder_cs_pipe #(
        .WIDTH (WIDTH),
        .SEG   (SEG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inValid     (inValid),
        .inReady     (inReady),
        .inA         (inA),
        .inB         (inB),
        .inCarry     (inCarry),
        .inSub       (inSub),
        .outValid    (outValid),
        .outReady    (outReady),
        .outSum      (outSum),
`ifdef ADDER_CS_PIPE_OVF_EN
        .outOverflow (outOverflow),
`endif
        .outCarry    (outCarry)
    );

    typedef struct {
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
        int          acc_cyc;
        int          acc_stall;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          pops = 0;
    exp_t        q[$];
    bit          front_seen = 0;
    bit          prev_hold = 0;
    logic [64:0] prev_res;
    bit          rand_rdy = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on unsigned and sign-extended operands.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [65:0] sa;
        logic [65:0] sb;
        logic [65:0] sr;
        sa = {{2{a[63]}}, a};
        sb = {{2{b[63]}}, b};
        if (sub) begin
            e.sum   = a - b;
            e.carry = (a >= b);
            sr      = sa - sb;
        end else begin
            {e.carry, e.sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            sr = sa + sb + {65'd0, cin};
        end
        e.ovf       = (sr[65:63] != 3'b000) && (sr[65:63] != 3'b111);
        e.acc_cyc   = 0;
        e.acc_stall = 0;
        return e;
    endfunction

    // Scoreboard: every cycle compare outputs with the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            front_seen = 0;
            prev_hold  = 0;
        end else begin
            chk("inready_rule", inReady, outReady || !outValid);
            if (prev_hold) begin
                chk("hold_valid", outValid, 1);
                chk("hold_result", {outCarry, outSum}, prev_res);
            end
            if (outValid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", outValid, 0);
                end else begin
                    chk("result", {outCarry, outSum}, {q[0].carry, q[0].sum});
`ifdef ADDER_CS_PIPE_OVF_EN
                    chk("overflow", outOverflow, q[0].ovf);
`endif
                    if (!front_seen) begin
                        chk("latency", cyc - q[0].acc_cyc, NSEG + stall_cnt - q[0].acc_stall);
                        front_seen = 1;
                    end
                    if (outReady) begin
                        void'(q.pop_front());
                        front_seen = 0;
                        pops++;
                    end
                end
            end else begin
                chk("idle_zero", {outCarry, outSum}, 0);
`ifdef ADDER_CS_PIPE_OVF_EN
                chk("idle_ovf_zero", outOverflow, 0);
`endif
            end
            prev_hold = outValid && !outReady;
            prev_res  = {outCarry, outSum};
            if (outValid && !outReady) stall_cnt++;
            if (inValid && inReady) begin
                e           = model(inA, inB, inCarry, inSub);
                e.acc_cyc   = cyc;
                e.acc_stall = stall_cnt;
                q.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            outReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the operand was taken.
    task automatic drive_op(input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub);
        bit acc = 0;
        int n = 0;
        inA = a; inB = b; inCarry = cin; inSub = sub; inValid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = inReady && rst_n;
            @(posedge clk);
            #1;
            n++;
        end
        inValid = 1'b0;
        chk("accept", acc, 1);
    endtask

    task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub,
                           input logic [64:0] exp_res, input logic exp_ovf);
        int   n = 0;
        exp_t m;
        outReady = 1'b1;
        m = model(a, b, cin, sub);
        chk({name, "_model"}, {m.ovf, m.carry, m.sum}, {exp_ovf, exp_res});
        drive_op(a, b, cin, sub);
        do begin
            @(negedge clk);
            n++;
        end while (!outValid && n < 20);
        chk({name, "_lat"}, n, NSEG);
        chk({name, "_res"}, {outCarry, outSum}, exp_res);
`ifdef ADDER_CS_PIPE_OVF_EN
        chk({name, "_ovf"}, outOverflow, exp_ovf);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] corner [4];
        corner[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        corner[1] = 64'h0;
        corner[2] = 64'h8000_0000_0000_0000;
        corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
        return {$urandom, $urandom};
    endfunction

    initial begin
        int p0;
        // Reset, with an operand presented that must not be taken.
        rst_n = 1'b0; outReady = 1'b1;
        inValid = 1'b1; inA = 64'd3; inB = 64'd4; inCarry = 1'b0; inSub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outvalid", outValid, 0);
        chk("rst_outsum", outSum, 0);
        chk("rst_outcarry", outCarry, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; inValid = 1'b0;
        @(negedge clk);
        chk("post_rst_inready", inReady, 1);
        chk("post_rst_outvalid", outValid, 0);
        @(posedge clk);
        #1;

        // Hand-computed cases.
        run_one("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                {1'b1, 64'd0}, 1'b0);
        run_one("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1,
                {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, 1'b0);
        run_one("sub_7_5", 64'd7, 64'd5, 1'b1, 1'b1,
                {1'b1, 64'd2}, 1'b0);
        run_one("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                {1'b0, 64'h8000_0000_0000_0000}, 1'b1);
        run_one("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                {1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, 1'b1);
        run_one("no_ovf", 64'd1, 64'd1, 1'b0, 1'b0,
                {1'b0, 64'd2}, 1'b0);

        // Back-to-back stream of 100 operands.
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            drive_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        chk("stream_count", pops - p0, 100);

        // Fill the pipe, then stall the output for 6 cycles with an operand waiting.
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            drive_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        outReady = 1'b0;
        inA = rnd64(); inB = rnd64(); inCarry = 1'b1; inSub = 1'b0; inValid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_inready", inReady, 0);
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        drive_op(inA, inB, inCarry, inSub);
        drain();
        chk("stall_count", pops - p0, 5);

        // Random input gaps and random output back-pressure.
        p0 = pops;
        rand_rdy = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            drive_op(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        outReady = 1'b1;
        drain();
        chk("random_count", pops - p0, 150);

        // Reset with three operations in flight; none may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            drive_op(rnd64(), rnd64(), 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("flush_outvalid", outValid, 0);
        chk("flush_inready", inReady, 1);
        repeat (10) @(posedge clk);
        #1;
        run_one("after_flush", 64'd10, 64'd20, 1'b1, 1'b0, {1'b0, 64'd31}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
